// File: rtl/system_clock_alarm_pkg.sv
// Shared constants for the time-of-day/alarm slave: register map, field limits, CTRL/STATUS bits.
package system_clock_alarm_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned SEC_W  = 6;
  localparam int unsigned MIN_W  = 6;
  localparam int unsigned HOUR_W = 5;
  localparam int unsigned SNZ_W  = 6;

  localparam logic [ADDR_W-1:0] ADDR_SEC      = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_MIN      = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_HOUR     = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_ALM_MIN  = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_ALM_HOUR = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_CTRL     = 3'd5;
  localparam logic [ADDR_W-1:0] ADDR_STATUS   = 3'd6;
  localparam logic [ADDR_W-1:0] ADDR_SNOOZE   = 3'd7;

  localparam int unsigned SEC_MAX  = 59;
  localparam int unsigned MIN_MAX  = 59;
  localparam int unsigned HOUR_MAX = 23;

  localparam int unsigned CTRL_RUN_BIT      = 0;
  localparam int unsigned CTRL_ALARM_EN_BIT = 1;
  localparam int unsigned CTRL_IRQ_EN_BIT   = 2;

  localparam int unsigned STATUS_FLAG_BIT = 0;
  localparam int unsigned STATUS_RUN_BIT  = 1;

  typedef struct packed {
    logic irq_en;
    logic alarm_en;
    logic run;
  } ctrl_t;

endpackage

// File: rtl/system_clock_alarm_if.sv
// Avalon-MM slave bus bundle shared by the Nios II side and the clock/alarm slave.
interface system_clock_alarm_if;
  import system_clock_alarm_pkg::*;

  logic              chipselect;
  logic [ADDR_W-1:0] address;
  logic              write_n;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;

  modport master (
    output chipselect,
    output address,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  chipselect,
    input  address,
    input  write_n,
    input  writedata,
    output readdata
  );

endinterface

// File: rtl/system_clock_alarm_digit.sv
// Modulo-N counter for one time field; load has priority over increment, carry fires on N-1 -> 0.
module system_clock_alarm_digit #(
  parameter int unsigned N = 60,
  parameter int unsigned W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] count_o,
  output logic [W-1:0] next_c_o,
  output logic         carry_c_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d   = count_q;
    carry_c_o = 1'b0;
    if (load_i) begin
      count_d = load_val_i;
    end else if (inc_i) begin
      if (count_q == W'(N - 1)) begin
        count_d   = '0;
        carry_c_o = 1'b1;
      end else begin
        count_d = count_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o  = count_q;
  assign next_c_o = count_d;

endmodule

// File: rtl/system_clock_alarm.sv
// Time-of-day clock with HH:MM alarm on an Avalon-MM slave, advanced by rising edges of tick.
// Optional snooze counter at address 7 is built when SYSTEM_CLOCK_ALARM_SNOOZE_EN is defined.
module system_clock_alarm
  import system_clock_alarm_pkg::*;
#(
  parameter int unsigned SNOOZE_MIN = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  system_clock_alarm_if.slave bus,
  output logic                irq,
  output logic                alarm
);

  logic              wr_c;
  logic              time_wr_c;
  logic              tick_edge_c;
  logic              tick_req_c;
  logic              adv_c;
  logic              tick_q;
  logic              tick_pend_q;
  logic              tick_pend_d;

  logic              sec_load_c;
  logic              min_load_c;
  logic              hour_load_c;
  logic [SEC_W-1:0]  sec_q;
  logic [MIN_W-1:0]  min_q;
  logic [HOUR_W-1:0] hour_q;
  logic [MIN_W-1:0]  min_next_c;
  logic [HOUR_W-1:0] hour_next_c;
  logic [SEC_W-1:0]  unused_sec_next;
  logic              unused_hour_carry;
  logic              sec_carry_c;
  logic              min_carry_c;

  ctrl_t             ctrl_q;
  ctrl_t             ctrl_d;
  logic [MIN_W-1:0]  alm_min_q;
  logic [MIN_W-1:0]  alm_min_d;
  logic [HOUR_W-1:0] alm_hour_q;
  logic [HOUR_W-1:0] alm_hour_d;
  logic              flag_q;
  logic              flag_d;
  logic              flag_clr_c;
  logic              alm_hit_c;

  logic              snz_load_c;
  logic              snz_expire_c;
  logic [SNZ_W-1:0]  snz_val_c;

  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  assign wr_c        = bus.chipselect & ~bus.write_n;
  assign time_wr_c   = wr_c & ((bus.address == ADDR_SEC) | (bus.address == ADDR_MIN) |
                               (bus.address == ADDR_HOUR));
  assign tick_edge_c = tick & ~tick_q;
  assign tick_req_c  = tick_edge_c | tick_pend_q;

  // A time write wins the cycle; the tick is parked one cycle and then applied.
  assign adv_c       = ctrl_q.run & tick_req_c & ~time_wr_c;
  assign tick_pend_d = ctrl_q.run & tick_req_c & time_wr_c;

  assign sec_load_c  = wr_c & (bus.address == ADDR_SEC)  & (bus.writedata <= DATA_W'(SEC_MAX));
  assign min_load_c  = wr_c & (bus.address == ADDR_MIN)  & (bus.writedata <= DATA_W'(MIN_MAX));
  assign hour_load_c = wr_c & (bus.address == ADDR_HOUR) & (bus.writedata <= DATA_W'(HOUR_MAX));

  system_clock_alarm_digit #(.N(SEC_MAX + 1), .W(SEC_W)) u_sec (
    .clk        (clk),
    .reset      (reset),
    .inc_i      (adv_c),
    .load_i     (sec_load_c),
    .load_val_i (bus.writedata[SEC_W-1:0]),
    .count_o    (sec_q),
    .next_c_o   (unused_sec_next),
    .carry_c_o  (sec_carry_c)
  );

  system_clock_alarm_digit #(.N(MIN_MAX + 1), .W(MIN_W)) u_min (
    .clk        (clk),
    .reset      (reset),
    .inc_i      (sec_carry_c),
    .load_i     (min_load_c),
    .load_val_i (bus.writedata[MIN_W-1:0]),
    .count_o    (min_q),
    .next_c_o   (min_next_c),
    .carry_c_o  (min_carry_c)
  );

  system_clock_alarm_digit #(.N(HOUR_MAX + 1), .W(HOUR_W)) u_hour (
    .clk        (clk),
    .reset      (reset),
    .inc_i      (min_carry_c),
    .load_i     (hour_load_c),
    .load_val_i (bus.writedata[HOUR_W-1:0]),
    .count_o    (hour_q),
    .next_c_o   (hour_next_c),
    .carry_c_o  (unused_hour_carry)
  );

  // A seconds carry means the advance lands on :00, so only HH:MM needs comparing.
  assign alm_hit_c = ctrl_q.alarm_en & sec_carry_c &
                     (min_next_c == alm_min_q) & (hour_next_c == alm_hour_q);

`ifdef SYSTEM_CLOCK_ALARM_SNOOZE_EN
  logic [SNZ_W-1:0] snz_q;
  logic [SNZ_W-1:0] snz_d;

  assign snz_load_c = wr_c & (bus.address == ADDR_SNOOZE) & flag_q;

  always_comb begin
    snz_d        = snz_q;
    snz_expire_c = 1'b0;
    if (snz_load_c) begin
      snz_d = SNZ_W'(SNOOZE_MIN);
    end else if (sec_carry_c && (snz_q != '0)) begin
      snz_d        = snz_q - SNZ_W'(1);
      snz_expire_c = (snz_q == SNZ_W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      snz_q <= '0;
    end else begin
      snz_q <= snz_d;
    end
  end

  assign snz_val_c = snz_q;
`else
  logic unused_snooze;

  assign snz_load_c    = 1'b0;
  assign snz_expire_c  = 1'b0;
  assign snz_val_c     = '0;
  assign unused_snooze = ^SNZ_W'(SNOOZE_MIN);
`endif

  // Alarm/control register updates; a flag set beats any coincident clear.
  always_comb begin
    ctrl_d     = ctrl_q;
    alm_min_d  = alm_min_q;
    alm_hour_d = alm_hour_q;
    flag_clr_c = snz_load_c;
    flag_d     = flag_q;
    if (wr_c) begin
      case (bus.address)
        ADDR_ALM_MIN: begin
          if (bus.writedata <= DATA_W'(MIN_MAX)) alm_min_d = bus.writedata[MIN_W-1:0];
        end
        ADDR_ALM_HOUR: begin
          if (bus.writedata <= DATA_W'(HOUR_MAX)) alm_hour_d = bus.writedata[HOUR_W-1:0];
        end
        ADDR_CTRL: begin
          ctrl_d.run      = bus.writedata[CTRL_RUN_BIT];
          ctrl_d.alarm_en = bus.writedata[CTRL_ALARM_EN_BIT];
          ctrl_d.irq_en   = bus.writedata[CTRL_IRQ_EN_BIT];
        end
        ADDR_STATUS: begin
          if (bus.writedata[STATUS_FLAG_BIT]) flag_clr_c = 1'b1;
        end
        default: ;
      endcase
    end
    if (alm_hit_c | snz_expire_c) begin
      flag_d = 1'b1;
    end else if (flag_clr_c) begin
      flag_d = 1'b0;
    end
  end

  always_comb begin
    rdata_d = '0;
    case (bus.address)
      ADDR_SEC:      rdata_d = DATA_W'(sec_q);
      ADDR_MIN:      rdata_d = DATA_W'(min_q);
      ADDR_HOUR:     rdata_d = DATA_W'(hour_q);
      ADDR_ALM_MIN:  rdata_d = DATA_W'(alm_min_q);
      ADDR_ALM_HOUR: rdata_d = DATA_W'(alm_hour_q);
      ADDR_CTRL: begin
        rdata_d[CTRL_RUN_BIT]      = ctrl_q.run;
        rdata_d[CTRL_ALARM_EN_BIT] = ctrl_q.alarm_en;
        rdata_d[CTRL_IRQ_EN_BIT]   = ctrl_q.irq_en;
      end
      ADDR_STATUS: begin
        rdata_d[STATUS_FLAG_BIT] = flag_q;
        rdata_d[STATUS_RUN_BIT]  = ctrl_q.run;
      end
      ADDR_SNOOZE:   rdata_d = DATA_W'(snz_val_c);
      default:       rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q      <= 1'b0;
      tick_pend_q <= 1'b0;
      ctrl_q      <= '0;
      alm_min_q   <= '0;
      alm_hour_q  <= '0;
      flag_q      <= 1'b0;
      rdata_q     <= '0;
    end else begin
      tick_q      <= tick;
      tick_pend_q <= tick_pend_d;
      ctrl_q      <= ctrl_d;
      alm_min_q   <= alm_min_d;
      alm_hour_q  <= alm_hour_d;
      flag_q      <= flag_d;
      rdata_q     <= rdata_d;
    end
  end

  assign bus.readdata = rdata_q;
  assign irq          = flag_q & ctrl_q.irq_en;
  assign alarm        = flag_q;

endmodule

// File: doc/system_clock_alarm.md
# system_clock_alarm

Avalon-MM slave that keeps hours/minutes/seconds time-of-day and raises an alarm interrupt on a programmed HH:MM match. It sits directly downstream of the 1 Hz interval timer. The timer's once-per-second timeout output drives `tick`. The Nios II core reads and sets time and alarm over the same 16-bit, 3-bit-address register bus used by the timer.

## Interface
- `SNOOZE_MIN`, default 5: minutes added by a snooze request, range 1–63.

Ports:
- `clk` in 1: system clock, 50 MHz.
- `reset` in 1: synchronous, active-high reset (decided: one clock, synchronous active-high reset).
- `tick` in 1: 1 Hz event; only the rising edge counts, so either a level or a pulse is accepted.
- `chipselect` in 1: Avalon slave select.
- `address` in 3: register index.
- `write_n` in 1: active-low write strobe.
- `writedata` in 16: write data.
- `readdata` out 16: registered read data.
- `irq` out 1: `alarm_flag & irq_en`.
- `alarm` out 1: raw `alarm_flag`, drives the buzzer/LED.

## Operation
- Register map, zero-extended on read:
  - 0 SEC, 6 bits.
  - 1 MIN, 6 bits.
  - 2 HOUR, 5 bits.
  - 3 ALM_MIN.
  - 4 ALM_HOUR.
  - 5 CTRL: bit0 `run`, bit1 `alarm_en`, bit2 `irq_en`.
  - 6 STATUS: bit0 `alarm_flag`, bit1 `run`, read-only mirror.
  - 7 SNOOZE: remaining snooze minutes.
- Write strobe is `chipselect & ~write_n`.
- Writes to 0–4 with values ≥ limit (60/60/24/60/24) are ignored and the register is unchanged.
- Writing STATUS with bit0 = 1 clears `alarm_flag`.
- Edge detect: `tick_q <= tick`, and `tick_edge = tick & ~tick_q`. `tick_edge` advances time only when `run` = 1.
- Advance chain:
  - SEC 59→0 carries into MIN.
  - MIN 59→0 carries into HOUR.
  - HOUR 23→0.
  - So 23:59:59 → 00:00:00.
- Alarm match: the advance produces SEC = 0, MIN = ALM_MIN, HOUR = ALM_HOUR, and `alarm_en` = 1. On a match `alarm_flag` sets on the same edge the time updates.
- Priority on `alarm_flag`: set beats clear; a STATUS clear coincident with a set leaves the flag at 1.
- Time write coincident with `tick_edge`:
  - The write wins for all time fields.
  - The tick is held in a one-deep `tick_pend` and applied on the next cycle.
  - A second tick never arrives within 1 s, so one stage is enough.
- Clearing `run` drops `tick_pend`.

## Timing
- Reset values: `readdata` = 0; all time, alarm and CTRL registers = 0; `alarm_flag` = 0; `tick_q` = 0; `tick_pend` = 0; snooze counter = 0; `irq` = 0; `alarm` = 0.
- Reset applied mid-operation returns every register to these values on that edge.
- Read latency: 1 cycle. `readdata` loads the mux output on every edge, whether or not chipselect is asserted, with no wait states.
- Write latency: the value is visible to a read issued on the next cycle.
- Tick path: the edge that first samples `tick` = 1 also updates time and `alarm_flag`. `irq` follows combinationally from the flag register.
- A deferred tick applies exactly one cycle later.

## Configuration
- `SYSTEM_CLOCK_ALARM_SNOOZE_EN` defined:
  - Writing address 7 while `alarm_flag` = 1 clears the flag and loads the snooze counter with `SNOOZE_MIN`.
  - The counter decrements on each MIN carry.
  - When it goes 1→0, `alarm_flag` sets. This set is independent of `alarm_en`.
  - Writing address 7 while the flag is 0 is ignored.
  - Reading address 7 returns the counter.
- Macro undefined: address 7 reads 0, writes to it have no effect, and no snooze logic is synthesized.

## Structure
- Shared package `system_clock_alarm_pkg` holds:
  - address constants `ADDR_SEC` … `ADDR_SNOOZE`;
  - limits `SEC_MAX` = 59, `MIN_MAX` = 59, `HOUR_MAX` = 23;
  - CTRL bit positions.
- One sub-module, `system_clock_alarm_digit`: a parameterized modulo-N counter with `inc`, `load`, `load_val` and a `carry` output. It is instantiated three times for SEC/MIN/HOUR.
- Avalon decode, alarm compare, snooze logic and read mux stay in the top level.

## Test plan
- **Reset values:** assert `reset` for 2 cycles, then read addresses 0–7 → all return 0; `irq` = 0, `alarm` = 0.
- **Midnight wrap:** write HOUR = 23, MIN = 59, SEC = 58, CTRL = 1, then give 2 tick edges → reads return 00:00:00.
- **Alarm and clear:**
  - Setup: ALM = 07:30, CTRL = 7, time 07:29:59.
  - One tick → `alarm` = 1 and `irq` = 1 on the same edge that SEC reads 0.
  - Write STATUS = 1 → `irq` = 0 next cycle.
- **Range check:** write SEC = 60, then HOUR = 24 → reads return the previous values.
- **Write/tick collision:** write MIN = 10 on the same cycle as a tick edge → MIN = 10, and SEC increments exactly one cycle later.
- **Snooze (macro defined, `SNOOZE_MIN` = 5):**
  - With `alarm_flag` = 1, write address 7 → flag 0, address 7 reads 5.
  - After 300 ticks → `alarm_flag` = 1.
  - With `run` = 0, ticks leave the time unchanged.
